led_rotator: RTL and testbench

LED_ROTATOR -- requirements
Module: led_rotator

---
 rtl/led_rotator_pkg.sv | 26 ++
 rtl/led_rotator_tick_gen.sv | 42 ++++
 rtl/led_rotator.sv | 73 +++++++
 tb/tb_led_rotator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_rotator_pkg.sv
// Shared definitions for the LED rotator: step-mode encodings, parameter limits
// and the prescaler counter width helper.
package led_rotator_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned DIV_MIN   = 1;
  localparam int unsigned DIV_MAX   = 65535;
  localparam int unsigned MODE_W    = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_ROL  = 2'b01,
    MODE_ROR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  // Bits needed to hold DIV-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned div);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(div)) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_rotator_tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle that completes a DIV period.
module tick_gen
  import led_rotator_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W    = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  always_comb begin
    at_last = (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear or reset in the terminal cycle suppresses the step.
  assign tick = en & at_last & ~clr & ~rst;

endmodule

// File: rtl/led_rotator.sv
// LED rotator: a WIDTH-bit register that rotates or shifts once per prescaled
// tick, with parallel load and an end-crossing wrap pulse.
module led_rotator
  import led_rotator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4,
  parameter logic [31:0] INIT  = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // Load beats any step; wrap only reports a set bit leaving an end under rotation.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = din;
    end else if (tick) begin
      case (mode_e'(mode))
        MODE_HOLD: q_d = q_q;
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          wrap_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          wrap_d = q_q[0];
        end
        MODE_SHL: q_d = {q_q[WIDTH-2:0], sin};
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= INIT[WIDTH-1:0];
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_rotator.sv
// Self-checking bench for led_rotator (WIDTH=8, DIV=4, INIT=1): directed
// scenarios followed by random traffic, all against a behavioural model.
module tb_led_rotator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV   = 4;
  localparam int unsigned INIT  = 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             wrap;

  int n_tests;
  int n_fail;

  // Reference model state: register value, enabled-cycle phase, pending wrap.
  int m_q;
  int m_phase;
  int m_wrap;

  bit obs_tick;
  bit obs_wrap;

  led_rotator #(
    .WIDTH (WIDTH),
    .DIV   (DIV),
    .INIT  (32'(INIT))
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .load (load),
    .din  (din),
    .sin  (sin),
    .q    (q),
    .tick (tick),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check tick mid-cycle, advance model, check q/wrap after the edge.
  task automatic cyc(input bit r, input bit e, input bit [1:0] m, input bit l,
                     input bit [7:0] d, input bit s);
    bit exp_tick;
    rst  = r;
    en   = e;
    mode = m;
    load = l;
    din  = d;
    sin  = s;
    @(negedge clk);
    exp_tick = e && !l && !r && (m_phase == int'(DIV) - 1);
    obs_tick = tick;
    chk("tick", 32'(tick), 32'(exp_tick));
    if (r) begin
      m_q = int'(INIT) & 255; m_phase = 0; m_wrap = 0;
    end else if (l) begin
      m_q = int'(d); m_phase = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (exp_tick) begin
        case (m)
          2'b01: begin m_wrap = (m_q >> 7) & 1; m_q = ((m_q << 1) | (m_q >> 7)) & 255; end
          2'b10: begin m_wrap = m_q & 1;        m_q = ((m_q >> 1) | (m_q << 7)) & 255; end
          2'b11: m_q = ((m_q << 1) | int'(s)) & 255;
          default: ;
        endcase
      end
      if (e) m_phase = (m_phase + 1) % int'(DIV);
    end
    @(posedge clk);
    #1;
    obs_wrap = wrap;
    chk("q", 32'(q), 32'(m_q));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    int ticks;
    int wraps;
    int last_idx;
    bit [3:0] pat;
    n_tests = 0;
    n_fail  = 0;
    m_q = 0; m_phase = 0; m_wrap = 0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; din = '0; sin = 1'b0;

    // Reset, then rotate left for 32 cycles.
    cyc(1, 0, 2'b00, 0, 8'h00, 0);
    cyc(1, 1, 2'b01, 1, 8'hAA, 0);
    chk("reset_q", 32'(q), 32'h01);
    ticks = 0; wraps = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 2'b01, 0, 8'h00, 0);
      ticks += int'(obs_tick);
      wraps += int'(obs_wrap);
    end
    chk("rol_ticks", 32'(ticks), 32'd8);
    chk("rol_wraps", 32'(wraps), 32'd1);
    chk("rol_final_q", 32'(q), 32'h01);

    // Load 0x81, rotate right twice.
    cyc(0, 0, 2'b10, 1, 8'h81, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b10, 0, 8'h00, 0);
    chk("ror_step1_q", 32'(q), 32'hC0);
    chk("ror_step1_wrap", 32'(wrap), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b10, 0, 8'h00, 0);
    chk("ror_step2_q", 32'(q), 32'h60);
    chk("ror_step2_wrap", 32'(wrap), 32'd0);

    // Serial insert 1,0,1,1 from zero.
    pat = 4'b1011;
    cyc(0, 0, 2'b11, 1, 8'h00, 0);
    wraps = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin
        cyc(0, 1, 2'b11, 0, 8'h00, pat[3-k]);
        wraps += int'(obs_wrap);
      end
    chk("shl_q", 32'(q), 32'h0B);
    chk("shl_wraps", 32'(wraps), 32'd0);

    // Enable toggling on alternate cycles: one tick per 8 clocks.
    cyc(0, 0, 2'b01, 1, 8'h01, 0);
    ticks = 0; last_idx = -1;
    for (int i = 0; i < 32; i++) begin
      cyc(0, (i % 2) == 0, 2'b01, 0, 8'h00, 0);
      if (obs_tick) begin
        if (last_idx >= 0) chk("toggle_spacing", 32'(i - last_idx), 32'd8);
        last_idx = i;
        ticks++;
      end
    end
    chk("toggle_ticks", 32'(ticks), 32'd4);
    chk("toggle_q", 32'(q), 32'h10);

    // Load in the exact tick cycle.
    cyc(0, 1, 2'b01, 1, 8'h01, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01, 0, 8'h00, 0);
    cyc(0, 1, 2'b01, 1, 8'h55, 0);
    chk("load_tick_suppressed", 32'(obs_tick), 32'd0);
    chk("load_tick_q", 32'(q), 32'h55);
    last_idx = -1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2'b01, 0, 8'h00, 0);
      if (obs_tick && last_idx < 0) last_idx = i;
    end
    chk("load_next_tick_idx", 32'(last_idx), 32'd3);
    chk("load_next_q", 32'(q), 32'hAA);

    // Reset mid-count overrides load and discards phase.
    cyc(0, 0, 2'b01, 1, 8'h08, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b01, 0, 8'h00, 0);
    cyc(0, 1, 2'b00, 0, 8'h00, 0);
    cyc(0, 1, 2'b00, 0, 8'h00, 0);
    chk("pre_rst_q", 32'(q), 32'h10);
    cyc(1, 1, 2'b01, 1, 8'hFF, 0);
    chk("mid_rst_q", 32'(q), 32'h01);
    chk("mid_rst_wrap", 32'(wrap), 32'd0);
    last_idx = -1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2'b01, 0, 8'h00, 0);
      if (obs_tick && last_idx < 0) last_idx = i;
    end
    chk("rst_next_tick_idx", 32'(last_idx), 32'd3);
    chk("rst_next_q", 32'(q), 32'h02);

    // Zero under rotation stays zero.
    cyc(0, 0, 2'b01, 1, 8'h00, 0);
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, (i < 8) ? 2'b01 : 2'b10, 0, 8'h00, 0);
      wraps += int'(obs_wrap);
    end
    chk("zero_q", 32'(q), 32'h00);
    chk("zero_wraps", 32'(wraps), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(39) == 0),
          ($urandom_range(3) != 0),
          2'($urandom_range(3)),
          ($urandom_range(7) == 0),
          8'($urandom),
          1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
